// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared types for the APB3 requester bridge:
//     apb_state_e : transfer phase (IDLE -> SETUP -> ACCESS)
//     apb_rsp_t   : response payload held until the consumer takes it
//     ctr_width() : width of a counter that must hold 0..TIMEOUT
// -----------------------------------------------------------------------------
package apb_pkg;

  // Response payload width. The bridge's DATA_W defaults to this value.
  // The two must stay equal.
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // A width of zero is not legal, so a disabled timeout (0) still gets one bit.
  function automatic int ctr_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// apb_timeout_ctr
//   Counts ACCESS cycles spent with PREADY low. It flags the cycle in which the
//   TIMEOUT-th such cycle is being counted. TIMEOUT = 0 disables the flag.
//   Ports:
//     clk, rst_n : clock and asynchronous active-low reset
//     clear      : zero the count (start of a new transfer)
//     inc        : one more wait cycle observed this cycle
//     expired    : this wait cycle is the last one allowed; abort now
// -----------------------------------------------------------------------------
module apb_timeout_ctr
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int                CNT_W   = ctr_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: state held across clock edges is written with non-blocking (<=)
  // assignments, so every flop samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != CNT_MAX)) begin
      // Saturates rather than wrapping, so a stale count can never re-arm.
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && inc && (r_count == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB3 requester. It accepts one read or write command at a time on a
//   valid/ready port. For each command it runs one IDLE->SETUP->ACCESS
//   transfer. It returns read data and status on a one-entry valid/ready
//   response port. A slave that holds PREADY low for TIMEOUT ACCESS cycles
//   causes the transfer to abort with a timeout error.
//   Ports:
//     PCLK, RESETn              : clock, asynchronous active-low reset
//     cmd_valid/ready/write/addr/wdata : command port
//     rsp_valid/ready/rdata/err/timeout : response port
//                                 (rdata = 0 for writes and timeouts)
//     busy                      : a transfer is in progress
//     PSLEx, PENABLE, PWRITE,
//     PADDAR, PWDATA            : APB request outputs
//     PRDATA, PREADY, PSLVERR   : APB completion inputs, used only in ACCESS
//   Throughput: one transfer every 3 cycles, with zero-wait slaves.
// -----------------------------------------------------------------------------
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              RESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSLEx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDAR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        r_state;
  apb_state_e        w_state_next;
  logic              r_run;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  apb_rsp_t          r_rsp;
  apb_rsp_t          w_rsp;
  logic              w_rsp_load;
  logic              w_accept;
  logic              w_ctr_inc;
  logic              w_expired;

  // r_run is held low by reset and goes high on the first edge after reset
  // is released. This keeps cmd_ready at 0 while reset is asserted, even
  // though the FSM itself is in IDLE.
  // A new command can be taken only when the response slot is empty or is
  // being emptied in this cycle. As a result, an unconsumed response is
  // never overwritten.
  assign cmd_ready = r_run && (r_state == IDLE) && (!r_rsp_valid || rsp_ready);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_ctr_inc = (r_state == ACCESS) && !PREADY;
  assign busy      = (r_state != IDLE);

  apb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (PCLK),
    .rst_n   (RESETn),
    .clear   (w_accept),
    .inc     (w_ctr_inc),
    .expired (w_expired)
  );

  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_run   <= 1'b1;
    end
  end

  // NOTE: every signal written here gets a default before the case
  // statement. Without those defaults, a path that skips an assignment would
  // infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_rsp_load   = 1'b0;
    w_rsp        = '0;
    PSLEx        = 1'b0;
    PENABLE      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = SETUP;
      end
      SETUP: begin
        PSLEx        = 1'b1;
        w_state_next = ACCESS;
      end
      ACCESS: begin
        PSLEx   = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          w_rsp_load   = 1'b1;
          w_rsp.rdata  = r_pwrite ? '0 : PRDATA;
          w_rsp.err    = PSLVERR;
          w_state_next = IDLE;
        end else if (w_expired) begin
          w_rsp_load    = 1'b1;
          w_rsp.err     = 1'b1;
          w_rsp.timeout = 1'b1;
          w_state_next  = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The request fields load only when a command is accepted. They therefore
  // stay stable for the whole transfer, and they hold their last value in IDLE.
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  // If a new response loads in the same cycle that the old one is consumed,
  // the load takes priority.
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else if (w_rsp_load) begin
      r_rsp_valid <= 1'b1;
      r_rsp       <= w_rsp;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end
  end

  assign PWRITE      = r_pwrite;
  assign PADDAR      = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp.rdata;
  assign rsp_err     = r_rsp.err;
  assign rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge. It includes a small APB slave model
//   with programmable wait states, stuck-low PREADY, and PSLVERR modes.
//   All DUT outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              PCLK = 1'b0;
  logic              RESETn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic              PSLEx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDAR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK        (PCLK),
    .RESETn      (RESETn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .PSLEx       (PSLEx),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDAR      (PADDAR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  // ---------------- APB slave model ----------------
  logic [DATA_W-1:0] mem [256];
  int  wait_cycles = 0;
  bit  stuck       = 1'b0;
  int  err_mode    = 0;   // 0: never, 1: with PREADY, 2: only while PREADY=0
  int  acc_cnt     = 0;

  always_comb begin
    PREADY  = PSLEx && PENABLE && !stuck && (acc_cnt >= wait_cycles);
    PRDATA  = PREADY ? mem[PADDAR] : 32'hBAD0_BAD0;
    PSLVERR = 1'b0;
    if (err_mode == 1) PSLVERR = PREADY;
    else if (err_mode == 2) PSLVERR = PSLEx && PENABLE && !PREADY;
  end

  always @(posedge PCLK) begin
    if (PSLEx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PSLEx && PENABLE && PREADY && PWRITE) mem[PADDAR] <= PWDATA;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Offers a command and returns right after the accept edge, with the DUT
  // now in SETUP. The command inputs are then scrambled to show they are ignored.
  task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d);
    int k;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    #1;
    k = 0;
    while (!cmd_ready && k < 8) begin
      tick();
      k++;
    end
    check("issue_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = 8'hFF;
    cmd_wdata = 32'h0;
  endtask

  task automatic wait_rsp(input int max_cycles);
    int k;
    k = 0;
    while (!rsp_valid && k < max_cycles) begin
      tick();
      k++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_cleared", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stream vectors for the post-reset back-to-back run.
  bit          s_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0]  s_addr [4] = '{8'h40, 8'h41, 8'h40, 8'h41};
  logic [31:0] s_data [4] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0, 32'h0};
  logic [31:0] s_exp  [4] = '{32'h0, 32'h0, 32'hA5A5_0001, 32'h5A5A_0002};

  initial begin
    int  n;
    bit  addr_ok;
    int  idx, got, cyc;
    bit  acc;

    // 1: reset
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_flags", {rsp_err, rsp_timeout, busy}, 0);
    check("rst_apb_ctrl", {PSLEx, PENABLE, PWRITE}, 0);
    check("rst_paddr", PADDAR, 0);
    check("rst_pwdata", PWDATA, 0);
    RESETn = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_busy", busy, 0);

    // 2: zero-wait write 0x10 <= 0xDEADBEEF
    issue(1'b1, 8'h10, 32'hDEAD_BEEF);
    check("w_setup_sel_en", {PSLEx, PENABLE}, 2'b10);
    check("w_setup_addr", PADDAR, 8'h10);
    check("w_setup_dir_data", {PWRITE, PWDATA}, {1'b1, 32'hDEAD_BEEF});
    check("w_setup_no_rsp", rsp_valid, 0);
    tick();
    check("w_access_sel_en", {PSLEx, PENABLE}, 2'b11);
    check("w_access_no_rsp", rsp_valid, 0);
    tick();
    check("w_rsp_valid", rsp_valid, 1);
    check("w_rsp_payload", {rsp_rdata, rsp_err, rsp_timeout}, 0);
    check("w_idle_sel_en", {PSLEx, PENABLE, busy}, 0);
    check("w_addr_held", PADDAR, 8'h10);
    check("w_slave_mem", mem[8'h10], 32'hDEAD_BEEF);
    consume();

    // 3: read 0x10 with 4 wait cycles, response held while rsp_ready=0
    wait_cycles = 4;
    issue(1'b0, 8'h10, 32'h0);
    n = 0;
    addr_ok = 1'b1;
    while (busy && n < 20) begin
      if (PADDAR !== 8'h10 || PWRITE !== 1'b0) addr_ok = 1'b0;
      n++;
      tick();
    end
    check("r_busy_cycles", n, 6);
    check("r_paddr_stable", addr_ok, 1);
    check("r_rsp_valid", rsp_valid, 1);
    check("r_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("r_err", {rsp_err, rsp_timeout}, 0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h11;
    cmd_wdata = 32'h1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("r_hold_cmd_ready", cmd_ready, 0);
      tick();
      check("r_hold_valid", rsp_valid, 1);
    end
    check("r_hold_not_busy", busy, 0);
    rsp_ready = 1'b1;
    #1;
    check("r_ready_passthru", cmd_ready, 1);
    cmd_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    check("r_consumed", rsp_valid, 0);
    wait_cycles = 0;

    // 4: PSLVERR with PREADY counts; PSLVERR while PREADY=0 is ignored
    err_mode = 1;
    issue(1'b1, 8'h20, 32'h1234_5678);
    wait_rsp(6);
    check("e_err_flags", {rsp_err, rsp_timeout}, 2'b10);
    consume();
    err_mode = 2;
    wait_cycles = 2;
    issue(1'b0, 8'h10, 32'h0);
    wait_rsp(10);
    check("e_ignored_err", {rsp_err, rsp_timeout}, 0);
    check("e_ignored_rdata", rsp_rdata, 32'hDEAD_BEEF);
    consume();
    err_mode = 0;
    wait_cycles = 0;

    // 5: stuck PREADY -> timeout after 16 ACCESS cycles
    stuck = 1'b1;
    issue(1'b1, 8'h30, 32'hCAFE_F00D);
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (PSLEx && PENABLE) n++;
      tick();
    end
    check("t_access_cycles", n, 16);
    check("t_rsp_valid", rsp_valid, 1);
    check("t_flags", {rsp_err, rsp_timeout}, 2'b11);
    check("t_rdata", rsp_rdata, 0);
    check("t_bus_released", {PSLEx, PENABLE}, 0);
    stuck = 1'b0;
    consume();
    issue(1'b0, 8'h10, 32'h0);
    wait_rsp(6);
    check("t_next_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("t_next_flags", {rsp_err, rsp_timeout}, 0);
    consume();

    // 6: reset during ACCESS, then back-to-back stream
    wait_cycles = 10;
    issue(1'b0, 8'h10, 32'h0);
    tick();
    tick();
    check("x_in_access", {PSLEx, PENABLE}, 2'b11);
    #2;
    RESETn = 1'b0;
    #1;
    check("x_async_drop", {PSLEx, PENABLE, busy}, 0);
    check("x_no_rsp", rsp_valid, 0);
    wait_cycles = 0;
    tick();
    tick();
    check("x_held_no_rsp", {rsp_valid, cmd_ready}, 0);
    @(negedge PCLK);
    RESETn = 1'b1;
    tick();
    check("x_rel_cmd_ready", cmd_ready, 1);

    rsp_ready = 1'b1;
    idx = 0;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      cmd_valid = (idx < 4);
      if (idx < 4) begin
        cmd_write = s_wr[idx];
        cmd_addr  = s_addr[idx];
        cmd_wdata = s_data[idx];
      end
      #1;
      acc = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        check($sformatf("s_rdata%0d", got), rsp_rdata, s_exp[got]);
        check($sformatf("s_flags%0d", got), {rsp_err, rsp_timeout}, 0);
        got++;
      end
      tick();
      cyc++;
      if (acc) idx++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    check("s_all_rsp", got, 4);
    check("s_cycles", cyc, 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
